// File: rtl/snake_pkg.sv
// Shared definitions for the snake game datapath.
//   - direction encoding (UP=0, RIGHT=1, DOWN=2, LEFT=3)
//   - controller state encoding (IDLE, RUN, DEAD)
//   - playfield geometry defaults shared with the apple placer and renderer
package snake_pkg;

  localparam int CELL_DEFAULT  = 10;   // cell size in pixels
  localparam int H_MAX_DEFAULT = 630;  // largest legal head_x (640 - CELL)
  localparam int V_MAX_DEFAULT = 470;  // largest legal head_y (480 - CELL)

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_DOWN  = 2'd2,
    DIR_LEFT  = 2'd3
  } dir_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DEAD = 2'd2
  } state_e;

  // Opposite directions differ only in bit 1 with this encoding.
  function automatic logic is_reverse(input dir_e a, input dir_e b);
    return (a ^ b) == 2'd2;
  endfunction

endpackage

// File: rtl/snake_tick.sv
// Move-tick generator: counts 0..TICK_DIV-1 while enabled and pulses step
// on the last count, wrapping to 0 in the same cycle.
//   clk, reset : clock, asynchronous active-high reset
//   en         : count enable
//   clr        : synchronous clear, overrides en
//   step       : high during the cycle the counter holds TICK_DIV-1
module snake_tick #(
  parameter int TICK_DIV = 2500000
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic step
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] tick_cnt;

  assign step = en && !clr && (tick_cnt == LAST);

  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples the pre-edge values of its neighbours, whatever the order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_cnt <= '0;
    end else if (clr) begin
      tick_cnt <= '0;
    end else if (en) begin
      tick_cnt <= step ? '0 : tick_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/snake_ctrl.sv
// Snake movement and game-state controller.
// Steps the head one cell per move tick, detects wall collisions, and raises
// start/eat pulses for the apple placer. All outputs are registered.
//   clk, reset               : clock, asynchronous active-high reset
//   btn_up/right/down/left   : debounced direction levels (priority in that order)
//   btn_start                : debounced start level, acts on its rising edge
//   apple_x, apple_y         : current apple pixel position
//   head_x, head_y           : head pixel position
//   start_evt, eat_evt       : one-cycle event pulses
//   score                    : apples eaten, saturating at 255
//   game_over, running       : high while in DEAD / RUN
module snake_ctrl
  import snake_pkg::*;
#(
  parameter int CELL     = CELL_DEFAULT,
  parameter int H_MAX    = H_MAX_DEFAULT,
  parameter int V_MAX    = V_MAX_DEFAULT,
  parameter int TICK_DIV = 2500000,
  parameter int START_X  = 160,
  parameter int START_Y  = 240
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_up,
  input  logic       btn_right,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_start,
  input  logic [9:0] apple_x,
  input  logic [8:0] apple_y,
  output logic [9:0] head_x,
  output logic [8:0] head_y,
  output logic       start_evt,
  output logic       eat_evt,
  output logic [7:0] score,
  output logic       game_over,
  output logic       running
);

  state_e     state, state_next;
  dir_e       dir, pend_dir, req_dir;
  logic       req_valid;
  logic       btn_start_q;
  logic       start_go;
  logic       step;
  logic       moved;
  logic       collide;
  logic [9:0] next_x;
  logic [8:0] next_y;

  // RUN ignores the start button; IDLE and DEAD restart on its rising edge.
  assign start_go = btn_start && !btn_start_q && (state != ST_RUN);

  snake_tick #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .en    (state == ST_RUN),
    .clr   (state != ST_RUN),
    .step  (step)
  );

  // NOTE: every signal of a combinational block gets a default before any
  // branch, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    req_dir   = DIR_UP;
    req_valid = 1'b1;
    if      (btn_up)    req_dir = DIR_UP;
    else if (btn_right) req_dir = DIR_RIGHT;
    else if (btn_down)  req_dir = DIR_DOWN;
    else if (btn_left)  req_dir = DIR_LEFT;
    else                req_valid = 1'b0;
  end

  // Wall test precedes the arithmetic, so the head never wraps.
  always_comb begin
    next_x  = head_x;
    next_y  = head_y;
    collide = 1'b0;
    case (pend_dir)
      DIR_UP:    if (head_y == '0)          collide = 1'b1;
                 else                       next_y  = head_y - 9'(CELL);
      DIR_DOWN:  if (head_y == 9'(V_MAX))   collide = 1'b1;
                 else                       next_y  = head_y + 9'(CELL);
      DIR_LEFT:  if (head_x == '0)          collide = 1'b1;
                 else                       next_x  = head_x - 10'(CELL);
      DIR_RIGHT: if (head_x >= 10'(H_MAX))  collide = 1'b1;
                 else                       next_x  = head_x + 10'(CELL);
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE, ST_DEAD: if (start_go) state_next = ST_RUN;
      ST_RUN:           if (step && collide) state_next = ST_DEAD;
      default:          state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_x      <= 10'(START_X);
      head_y      <= 9'(START_Y);
      dir         <= DIR_RIGHT;
      pend_dir    <= DIR_RIGHT;
      score       <= '0;
      start_evt   <= 1'b0;
      eat_evt     <= 1'b0;
      moved       <= 1'b0;
      btn_start_q <= 1'b0;
      game_over   <= 1'b0;
      running     <= 1'b0;
    end else begin
      btn_start_q <= btn_start;
      start_evt   <= 1'b0;
      eat_evt     <= 1'b0;
      moved       <= 1'b0;
      game_over   <= (state_next == ST_DEAD);
      running     <= (state_next == ST_RUN);

      if (start_go) begin
        head_x    <= 10'(START_X);
        head_y    <= 9'(START_Y);
        dir       <= DIR_RIGHT;
        pend_dir  <= DIR_RIGHT;
        score     <= '0;
        start_evt <= 1'b1;
      end else if (state == ST_RUN) begin
        // Checking against the committed dir (not pend_dir) means no press
        // sequence between two steps can reverse the snake.
        if (req_valid && !is_reverse(req_dir, dir)) pend_dir <= req_dir;

        if (step) begin
          dir <= pend_dir;
          if (!collide) begin
            head_x <= next_x;
            head_y <= next_y;
            moved  <= 1'b1;
          end
        end

        // Compared only right after a move: one landing, one eat pulse.
        if (moved && head_x == apple_x && head_y == apple_y) begin
          eat_evt <= 1'b1;
          if (score != 8'hFF) score <= score + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_snake_ctrl.sv
// Scoreboard bench for snake_ctrl with a 4-cycle move tick.
// Stimulus pushes expected events (start, move, eat, death) into a queue; a
// monitor on the falling edge pops and compares each event the DUT presents,
// including the cycle gap since the previous event.
module tb_snake_ctrl;

  localparam int EV_NONE  = 0;
  localparam int EV_START = 1;
  localparam int EV_MOVE  = 2;
  localparam int EV_EAT   = 3;
  localparam int EV_DEAD  = 4;

  typedef struct {
    int kind;
    int x;
    int y;
    int score;
    int run;
    int gap;   // cycles since previous event, -1 = unconstrained
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn_up = 1'b0, btn_right = 1'b0, btn_down = 1'b0, btn_left = 1'b0;
  logic       btn_start = 1'b0;
  logic [9:0] apple_x = 10'd1023;
  logic [8:0] apple_y = 9'd511;
  logic [9:0] head_x;
  logic [8:0] head_y;
  logic       start_evt, eat_evt, game_over, running;
  logic [7:0] score;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   last_cyc = 0;
  exp_t exp_q[$];

  logic [9:0] prev_x;
  logic [8:0] prev_y;
  logic       prev_go;

  snake_ctrl #(.TICK_DIV(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .btn_up    (btn_up),
    .btn_right (btn_right),
    .btn_down  (btn_down),
    .btn_left  (btn_left),
    .btn_start (btn_start),
    .apple_x   (apple_x),
    .apple_y   (apple_y),
    .head_x    (head_x),
    .head_y    (head_y),
    .start_evt (start_evt),
    .eat_evt   (eat_evt),
    .score     (score),
    .game_over (game_over),
    .running   (running)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input int actual, input int expected);
    n_tests++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic expect_ev(input int kind, input int x, input int y,
                           input int sc, input int run, input int gap);
    exp_t e;
    e.kind = kind; e.x = x; e.y = y; e.score = sc; e.run = run; e.gap = gap;
    exp_q.push_back(e);
  endtask

  task automatic take(input int kind);
    exp_t e;
    if (exp_q.size() == 0) begin
      check("unexpected event", kind, EV_NONE);
      return;
    end
    e = exp_q.pop_front();
    check("event kind", kind, e.kind);
    check("event head_x", int'(head_x), e.x);
    check("event head_y", int'(head_y), e.y);
    check("event score", int'(score), e.score);
    check("event running", int'(running), e.run);
    if (e.gap >= 0) check("event gap", cyc - last_cyc, e.gap);
    last_cyc = cyc;
  endtask

  // Monitor: classifies what the DUT shows after each rising edge.
  always @(negedge clk) begin
    if (reset) begin
      prev_x  = head_x;
      prev_y  = head_y;
      prev_go = game_over;
    end else begin
      if (start_evt) take(EV_START);
      else if (head_x != prev_x || head_y != prev_y) take(EV_MOVE);
      if (eat_evt) take(EV_EAT);
      if (game_over && !prev_go) take(EV_DEAD);
      prev_x  = head_x;
      prev_y  = head_y;
      prev_go = game_over;
    end
  end

  // Waits for the monitor to consume every queued expectation.
  task automatic drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("drain within budget", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " head_x"},    int'(head_x),    160);
    check({tag, " head_y"},    int'(head_y),    240);
    check({tag, " score"},     int'(score),     0);
    check({tag, " start_evt"}, int'(start_evt), 0);
    check({tag, " eat_evt"},   int'(eat_evt),   0);
    check({tag, " game_over"}, int'(game_over), 0);
    check({tag, " running"},   int'(running),   0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values.
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("idle running", int'(running), 0);

    // Start with btn_start held, then three plain steps to the right.
    expect_ev(EV_START, 160, 240, 0, 1, -1);
    expect_ev(EV_MOVE,  170, 240, 0, 1, 4);
    expect_ev(EV_MOVE,  180, 240, 0, 1, 4);
    expect_ev(EV_MOVE,  190, 240, 0, 1, 4);
    btn_start = 1'b1;
    drain(40);

    // Left alone while moving right is ignored; apple in the landing cell.
    apple_x  = 10'd200;
    apple_y  = 9'd240;
    btn_left = 1'b1;
    btn_start = 1'b0;
    expect_ev(EV_MOVE, 200, 240, 0, 1, 4);
    expect_ev(EV_EAT,  200, 240, 1, 1, 1);
    @(negedge clk);
    btn_left = 1'b0;
    drain(20);

    // Left then up within one step: turns up, never reverses.
    expect_ev(EV_MOVE, 200, 230, 1, 1, 3);
    btn_left = 1'b1;
    @(negedge clk);
    btn_left = 1'b0;
    btn_up   = 1'b1;
    @(negedge clk);
    btn_up   = 1'b0;
    drain(20);
    apple_x = 10'd1023;
    apple_y = 9'd511;

    // Turn right and run into the right wall at x=630.
    for (int x = 210; x <= 630; x += 10) expect_ev(EV_MOVE, x, 230, 1, 1, 4);
    expect_ev(EV_DEAD, 630, 230, 1, 0, 4);
    btn_right = 1'b1;
    @(negedge clk);
    btn_right = 1'b0;
    drain(400);
    repeat (12) @(negedge clk);
    check("dead game_over", int'(game_over), 1);
    check("dead running",   int'(running),   0);
    check("dead head_x",    int'(head_x),    630);

    // Restart from DEAD, then eat three apples in a row.
    expect_ev(EV_START, 160, 240, 0, 1, -1);
    btn_start = 1'b1;
    drain(20);
    btn_start = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      apple_x = 10'(160 + 10 * k);
      apple_y = 9'd240;
      expect_ev(EV_MOVE, 160 + 10 * k, 240, k - 1, 1, (k == 1) ? 4 : 3);
      expect_ev(EV_EAT,  160 + 10 * k, 240, k,     1, 1);
      drain(20);
    end

    // Asynchronous reset mid-run with score 3.
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_reset_outputs("mid-run reset");
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    check("post-reset running",   int'(running),   0);
    check("post-reset game_over", int'(game_over), 0);
    check("post-reset score",     int'(score),     0);
    check("pending expectations", exp_q.size(),    0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
